switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//   Input-side counterpart to the board's LED drivers. Samples a raw slide-switch or
//   push-button, synchronises it to CLOCK and rejects bounce. Delivers a clean level,
//   single-cycle rise/fall strobes and a wrap-around press counter.
//   Feeds LED/control logic that must only see debounced switch activity.
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000  cycles input must be stable to be accepted (10 ms @ 100 MHz); must be >= 1
//   PRESS_W          8          width of press_count
//   CNT_W            $clog2(DEBOUNCE_CYCLES+1)  stability counter width (localparam, not overridable)
// PORTS
//   CLOCK        in   1        system clock, all logic on posedge
//   reset        in   1        synchronous, active-low reset (0 = reset)
//   SW_IN        in   1        raw asynchronous switch/button input
//   sw_level     out  1        debounced switch level
//   sw_rise      out  1        one-cycle strobe: debounced 0->1
//   sw_fall      out  1        one-cycle strobe: debounced 1->0
//   press_count  out  PRESS_W  number of accepted rises, modulo 2^PRESS_W
// BEHAVIOUR
//   Reset (reset==0 at posedge)
//   - sync0, sync1, sw_level, sw_rise, sw_fall, press_count, stability counter -> 0; state -> LOW.
//   - Applies regardless of state or SW_IN.
//   Synchroniser
//   - sync0 <= SW_IN; sync1 <= sync0. The FSM sees only s = sync1.
//   FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW
//   - LOW: s==1 -> WAIT_HIGH, cnt <= 0.
//   - WAIT_HIGH, s==0 -> LOW, cnt <= 0, no strobe.
//   - WAIT_HIGH, s==1, cnt==DEBOUNCE_CYCLES-1 -> HIGH, sw_level <= 1, sw_rise <= 1,
//     press_count <= press_count+1 (wraps at 2^PRESS_W-1 -> 0).
//   - WAIT_HIGH, s==1, otherwise: cnt <= cnt+1.
//   - HIGH and WAIT_LOW mirror LOW and WAIT_HIGH with polarity inverted.
//     WAIT_LOW completion -> LOW, sw_level <= 0, sw_fall <= 1; press_count unchanged.
//   Strobes
//   - Registered; high for exactly one cycle, coincident with the sw_level change.
//   - sw_rise and sw_fall are never high together.
//   Latency
//   - SW_IN stable from sampling edge 1 -> sw_level/strobe update at edge DEBOUNCE_CYCLES+3.
//   - Any s reversal during WAIT_* restarts qualification from LOW/HIGH; the full latency applies again.
//   Reset release with SW_IN held 1
//   - Treated as a fresh press: rise + count after DEBOUNCE_CYCLES+3 edges.
// TESTING (DEBOUNCE_CYCLES=4 -> latency 7, PRESS_W=2 unless noted)
//   1. reset=0 3 cycles, SW_IN=1 -> all outputs 0.
//      Release reset with SW_IN held 1 -> sw_level=1, sw_rise=1 for 1 cycle at edge 7, press_count=1.
//   2. SW_IN=1 for 3 cycles then 0 -> sw_level stays 0; no strobes; press_count stays 0.
//   3. SW_IN=1 for 20 cycles then 0 ->
//      - sw_rise at edge 7, then sw_fall 7 edges after SW_IN drops.
//      - Each strobe is 1 cycle wide; press_count=1.
//   4. SW_IN toggles every 2 cycles for 10 cycles, then held 1 ->
//      - exactly one sw_rise, 7 edges after the final 0->1 transition.
//   5. Five clean press/release pairs -> press_count sequence 1,2,3,0,1; final value 1.
//   6. Assert reset=0 while in WAIT_HIGH (SW_IN=1, 2 edges into the count) ->
//      - next edge: all outputs 0, no strobe.
//      - After release: rise again at edge 7.

Source files
------------

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus four-state qualifier for a bouncy switch input.
// Emits a clean level, one-cycle rise/fall strobes and a wrapping press count.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PRESS_W         = 8
) (
  input  logic               CLOCK,
  input  logic               reset,
  input  logic               SW_IN,
  output logic               sw_level,
  output logic               sw_rise,
  output logic               sw_fall,
  output logic [PRESS_W-1:0] press_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW,
    WAIT_HIGH,
    HIGH,
    WAIT_LOW
  } state_e;

  state_e state_q, state_d;

  logic               sync0_q, sync1_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               level_q, level_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic [PRESS_W-1:0] press_q, press_d;

  logic s;
  logic cnt_done;

  assign s        = sync1_q;
  assign cnt_done = (cnt_q == CNT_MAX);

  always_ff @(posedge CLOCK) begin
    if (!reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= SW_IN;
      sync1_q <= sync0_q;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!reset) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      press_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      press_q <= press_d;
    end
  end

  // A reversal inside a WAIT state drops back to the settled state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOW: begin
        if (s) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (!s)           state_d = LOW;
        else if (cnt_done) state_d = HIGH;
      end
      HIGH: begin
        if (!s) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (s)            state_d = HIGH;
        else if (cnt_done) state_d = LOW;
      end
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    press_d = press_q;
    unique case (state_q)
      LOW: begin
        if (s) cnt_d = '0;
      end
      WAIT_HIGH: begin
        if (!s) begin
          cnt_d = '0;
        end else if (cnt_done) begin
          level_d = 1'b1;
          rise_d  = 1'b1;
          press_d = press_q + PRESS_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s) cnt_d = '0;
      end
      WAIT_LOW: begin
        if (s) begin
          cnt_d = '0;
        end else if (cnt_done) begin
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  assign sw_level    = level_q;
  assign sw_rise     = rise_q;
  assign sw_fall     = fall_q;
  assign press_count = press_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench: stimulus queues expected strobes, a monitor
// pops and checks them whenever the DUT raises sw_rise or sw_fall.
module tb_switch_debouncer;

  localparam int DC = 4;
  localparam int PW = 2;
  localparam int LAT = 7;

  logic          CLOCK;
  logic          reset;
  logic          SW_IN;
  logic          sw_level;
  logic          sw_rise;
  logic          sw_fall;
  logic [PW-1:0] press_count;

  typedef struct packed {
    logic          rise;
    logic          fall;
    logic [31:0]   cyc;
    logic          level;
    logic [PW-1:0] cnt;
  } ev_t;

  ev_t exp_q[$];
  int  cyc;
  int  passed;
  int  total;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DC),
    .PRESS_W(PW)
  ) dut (
    .CLOCK(CLOCK),
    .reset(reset),
    .SW_IN(SW_IN),
    .sw_level(sw_level),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .press_count(press_count)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  always @(negedge CLOCK) begin
    ev_t act;
    ev_t exp;
    if (sw_rise || sw_fall) begin
      act = '{rise: sw_rise, fall: sw_fall, cyc: 32'(cyc),
              level: sw_level, cnt: press_count};
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_strobe: got rise=%0b fall=%0b cyc=%0d lvl=%0b cnt=%0d, required none",
                 act.rise, act.fall, act.cyc, act.level, act.cnt);
      end else begin
        exp = exp_q.pop_front();
        if (act === exp) passed++;
        else
          $display("FAIL strobe_event: got rise=%0b fall=%0b cyc=%0d lvl=%0b cnt=%0d, required rise=%0b fall=%0b cyc=%0d lvl=%0b cnt=%0d",
                   act.rise, act.fall, act.cyc, act.level, act.cnt,
                   exp.rise, exp.fall, exp.cyc, exp.level, exp.cnt);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic expect_ev(input logic r, input logic [PW-1:0] c);
    ev_t e;
    e.rise  = r;
    e.fall  = ~r;
    e.cyc   = 32'(cyc + LAT);
    e.level = r;
    e.cnt   = c;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    SW_IN = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(3);
  endtask

  int outs;
  logic [PW-1:0] seq5 [5];

  initial begin
    seq5[0] = 2'd1; seq5[1] = 2'd2; seq5[2] = 2'd3;
    seq5[3] = 2'd0; seq5[4] = 2'd1;
    passed = 0;
    total  = 0;
    reset  = 1'b0;
    SW_IN  = 1'b1;

    // 1: reset with switch held high, then release = fresh press
    tick(3);
    outs = {sw_level, sw_rise, sw_fall, press_count};
    check("reset_outputs", outs, 0);
    reset = 1'b1;
    expect_ev(1'b1, 2'd1);
    tick(12);
    check("t1_level_high", int'(sw_level), 1);
    SW_IN = 1'b0;
    expect_ev(1'b0, 2'd1);
    tick(10);
    check("t1_level_low", int'(sw_level), 0);

    // 2: 3-cycle glitch rejected
    do_reset();
    SW_IN = 1'b1;
    tick(3);
    SW_IN = 1'b0;
    tick(10);
    check("t2_glitch", int'({sw_level, press_count}), 0);

    // boundary: 4-cycle pulse rejected, 5-cycle pulse accepted
    SW_IN = 1'b1;
    tick(4);
    SW_IN = 1'b0;
    tick(10);
    check("pulse4_rejected", int'({sw_level, press_count}), 0);
    SW_IN = 1'b1;
    expect_ev(1'b1, 2'd1);
    tick(5);
    SW_IN = 1'b0;
    expect_ev(1'b0, 2'd1);
    tick(12);
    check("pulse5_count", int'(press_count), 1);

    // 3: long press
    do_reset();
    SW_IN = 1'b1;
    expect_ev(1'b1, 2'd1);
    tick(20);
    SW_IN = 1'b0;
    expect_ev(1'b0, 2'd1);
    tick(10);
    check("t3_count", int'(press_count), 1);

    // 4: bouncing then held high
    do_reset();
    for (int i = 0; i < 10; i++) begin
      SW_IN = ((i / 2) % 2) == 0;
      if (i == 8) expect_ev(1'b1, 2'd1);
      tick(1);
    end
    tick(12);
    check("t4_level", int'(sw_level), 1);
    check("t4_count", int'(press_count), 1);
    SW_IN = 1'b0;
    expect_ev(1'b0, 2'd1);
    tick(10);

    // 5: five presses, wrap at 2 bits
    do_reset();
    for (int p = 0; p < 5; p++) begin
      SW_IN = 1'b1;
      expect_ev(1'b1, seq5[p]);
      tick(10);
      SW_IN = 1'b0;
      expect_ev(1'b0, seq5[p]);
      tick(10);
    end
    check("t5_final_count", int'(press_count), 1);

    // 6: reset while qualifying a press
    do_reset();
    SW_IN = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(1);
    outs = {sw_level, sw_rise, sw_fall, press_count};
    check("t6_reset_outputs", outs, 0);
    tick(2);
    reset = 1'b1;
    expect_ev(1'b1, 2'd1);
    tick(10);
    check("t6_level", int'(sw_level), 1);
    check("t6_count", int'(press_count), 1);

    tick(5);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
